// File: rtl/riscv_ex_wb_buffer_pkg.sv
// Shared types and constants for the EX->WB decoupling buffer.
// Optional forwarding taps are enabled with RISCV_EXWB_FWD_EN.
package riscv_ex_wb_buffer_pkg;

  // Number of entries held between EX and WB (head + skid).
  localparam int unsigned EXWB_DEPTH = 2;

  // Default core widths, used by exwb_entry_t for consumers outside the buffer.
  localparam int unsigned EXWB_DATA_WIDTH     = 32;
  localparam int unsigned EXWB_REG_ADDR_WIDTH = 6;

  // Buffer occupancy.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } exwb_state_e;

  // One buffered writeback entry.
  typedef struct packed {
    logic [EXWB_REG_ADDR_WIDTH-1:0] waddr;
    logic [EXWB_DATA_WIDTH-1:0]     wdata;
    logic                           we;
  } exwb_entry_t;

endpackage

// File: rtl/riscv_ex_wb_buffer_if.sv
// EX-side, WB-side and branch-resolution signals of the EX->WB buffer.
// Forwarding taps exist only when RISCV_EXWB_FWD_EN is defined.
interface riscv_ex_wb_buffer_if
  import riscv_ex_wb_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 6
);

  // EX side
  logic                      ex_valid_i;
  logic                      ex_ready_o;
  logic [DATA_WIDTH-1:0]     ex_result_i;
  logic                      ex_cmp_i;
  logic [REG_ADDR_WIDTH-1:0] ex_waddr_i;
  logic                      ex_we_i;
  logic                      ex_branch_i;
  logic [DATA_WIDTH-1:0]     ex_target_i;

  // WB side
  logic                      wb_valid_o;
  logic                      wb_ready_i;
  logic [REG_ADDR_WIDTH-1:0] wb_waddr_o;
  logic [DATA_WIDTH-1:0]     wb_wdata_o;
  logic                      wb_we_o;

  // Branch resolution
  logic                      branch_taken_o;
  logic [DATA_WIDTH-1:0]     branch_target_o;

`ifdef RISCV_EXWB_FWD_EN
  // Index 0 = head (older), index 1 = skid (younger)
  logic [EXWB_DEPTH-1:0]     fwd_valid_o;
  logic [REG_ADDR_WIDTH-1:0] fwd_waddr_o [EXWB_DEPTH];
  logic [DATA_WIDTH-1:0]     fwd_wdata_o [EXWB_DEPTH];
`endif

  // Buffer side
  modport slave (
    input  ex_valid_i, ex_result_i, ex_cmp_i, ex_waddr_i, ex_we_i, ex_branch_i, ex_target_i,
    input  wb_ready_i,
    output ex_ready_o, wb_valid_o, wb_waddr_o, wb_wdata_o, wb_we_o,
`ifdef RISCV_EXWB_FWD_EN
    output fwd_valid_o, fwd_waddr_o, fwd_wdata_o,
`endif
    output branch_taken_o, branch_target_o
  );

  // Pipeline / environment side
  modport master (
    output ex_valid_i, ex_result_i, ex_cmp_i, ex_waddr_i, ex_we_i, ex_branch_i, ex_target_i,
    output wb_ready_i,
    input  ex_ready_o, wb_valid_o, wb_waddr_o, wb_wdata_o, wb_we_o,
`ifdef RISCV_EXWB_FWD_EN
    input  fwd_valid_o, fwd_waddr_o, fwd_wdata_o,
`endif
    input  branch_taken_o, branch_target_o
  );

endinterface

// File: rtl/riscv_ex_wb_buffer.sv
// Two-entry skid buffer between the ALU (EX) and writeback.
// ex_ready_o is a flop, so WB stalls never reach EX combinationally.
// Define RISCV_EXWB_FWD_EN to expose both entries to operand forwarding.
module riscv_ex_wb_buffer
  import riscv_ex_wb_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  riscv_ex_wb_buffer_if.slave       bus
);

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      we;
  } entry_t;

  exwb_state_e           state_q, state_d;
  entry_t                head_q, head_d;
  entry_t                skid_q, skid_d;
  entry_t                in_entry;
  logic                  ex_ready_q, ex_ready_d;
  logic                  br_taken_q, br_taken_d;
  logic [DATA_WIDTH-1:0] br_target_q, br_target_d;
  logic                  accept;
  logic                  pop;

  assign in_entry = '{waddr: bus.ex_waddr_i, wdata: bus.ex_result_i, we: bus.ex_we_i};
  assign accept   = bus.ex_valid_i & ex_ready_q;
  assign pop      = (state_q != StEmpty) & bus.wb_ready_i;

  // Next-state: occupancy FSM, entry movement and branch resolution
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    skid_d      = skid_q;
    br_taken_d  = 1'b0;
    br_target_d = br_target_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          head_d  = in_entry;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && pop) begin
          head_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // ex_ready_o is low here, so only a pop can happen
        if (pop) begin
          head_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase

    if (accept && bus.ex_branch_i) begin
      br_taken_d  = bus.ex_cmp_i;
      br_target_d = bus.ex_target_i;
    end

    // Flush beats accept; entry registers keep their contents so wb_* hold steady
    if (flush_i) begin
      state_d     = StEmpty;
      head_d      = head_q;
      skid_d      = skid_q;
      br_taken_d  = 1'b0;
      br_target_d = br_target_q;
    end

    ex_ready_d = (state_d != StFull);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      head_q      <= '0;
      skid_q      <= '0;
      ex_ready_q  <= 1'b1;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      ex_ready_q  <= ex_ready_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
    end
  end

  assign bus.ex_ready_o      = ex_ready_q;
  assign bus.wb_valid_o      = (state_q != StEmpty);
  assign bus.wb_waddr_o      = head_q.waddr;
  assign bus.wb_wdata_o      = head_q.wdata;
  assign bus.wb_we_o         = (state_q != StEmpty) & head_q.we;
  assign bus.branch_taken_o  = br_taken_q;
  assign bus.branch_target_o = br_target_q;

`ifdef RISCV_EXWB_FWD_EN
  // Consumer resolves same-address hits; skid (index 1) is younger and wins
  assign bus.fwd_valid_o[0] = (state_q != StEmpty) & head_q.we;
  assign bus.fwd_valid_o[1] = (state_q == StFull) & skid_q.we;
  assign bus.fwd_waddr_o[0] = head_q.waddr;
  assign bus.fwd_waddr_o[1] = skid_q.waddr;
  assign bus.fwd_wdata_o[0] = head_q.wdata;
  assign bus.fwd_wdata_o[1] = skid_q.wdata;
`endif

endmodule

// File: tb/tb_riscv_ex_wb_buffer.sv
// Directed self-checking bench for riscv_ex_wb_buffer.
// Forwarding checks are compiled in when RISCV_EXWB_FWD_EN is defined.
module tb_riscv_ex_wb_buffer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  riscv_ex_wb_buffer_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus_if ();

  riscv_ex_wb_buffer #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (AW)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .bus     (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [DW-1:0] res, input logic [AW-1:0] wa,
                          input logic we, input logic br, input logic cmp,
                          input logic [DW-1:0] tgt);
    bus_if.ex_valid_i  = v;
    bus_if.ex_result_i = res;
    bus_if.ex_waddr_i  = wa;
    bus_if.ex_we_i     = we;
    bus_if.ex_branch_i = br;
    bus_if.ex_cmp_i    = cmp;
    bus_if.ex_target_i = tgt;
  endtask

  initial begin
    rst_n             = 1'b0;
    flush_i           = 1'b0;
    bus_if.wb_ready_i = 1'b0;
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    tick();

    // Reset state
    check("rst_ex_ready", bus_if.ex_ready_o, 1);
    check("rst_wb_valid", bus_if.wb_valid_o, 0);
    check("rst_wb_we", bus_if.wb_we_o, 0);
    check("rst_br_taken", bus_if.branch_taken_o, 0);
    check("rst_wb_waddr", bus_if.wb_waddr_o, 0);
    check("rst_wb_wdata", bus_if.wb_wdata_o, 0);
    check("rst_br_target", bus_if.branch_target_o, 0);
    rst_n = 1'b1;
    tick();

    // Single entry
    drive_ex(1'b1, 32'h0000_1234, 6'd5, 1'b1, 1'b0, 1'b0, '0);
    tick();
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    check("single_valid", bus_if.wb_valid_o, 1);
    check("single_wdata", bus_if.wb_wdata_o, 32'h1234);
    check("single_waddr", bus_if.wb_waddr_o, 5);
    check("single_we", bus_if.wb_we_o, 1);
    check("single_ready", bus_if.ex_ready_o, 1);
    bus_if.wb_ready_i = 1'b1;
    tick();
    bus_if.wb_ready_i = 1'b0;
    check("single_popped", bus_if.wb_valid_o, 0);
    check("single_we_gated", bus_if.wb_we_o, 0);
    check("single_hold_wdata", bus_if.wb_wdata_o, 32'h1234);

    // Backpressure: A then B, C offered while full must be refused
    drive_ex(1'b1, 32'd1, 6'd1, 1'b1, 1'b0, 1'b0, '0);
    tick();
    check("bp_ready_after_a", bus_if.ex_ready_o, 1);
    drive_ex(1'b1, 32'd2, 6'd2, 1'b1, 1'b0, 1'b0, '0);
    tick();
    check("bp_ready_full", bus_if.ex_ready_o, 0);
    check("bp_head_a", bus_if.wb_wdata_o, 1);
    drive_ex(1'b1, 32'd3, 6'd3, 1'b1, 1'b0, 1'b0, '0);
    tick();
    check("bp_still_full", bus_if.ex_ready_o, 0);
    check("bp_head_still_a", bus_if.wb_wdata_o, 1);
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    bus_if.wb_ready_i = 1'b1;
    tick();
    check("bp_pop_b_data", bus_if.wb_wdata_o, 2);
    check("bp_pop_b_addr", bus_if.wb_waddr_o, 2);
    check("bp_ready_back", bus_if.ex_ready_o, 1);
    tick();
    check("bp_drained", bus_if.wb_valid_o, 0);
    check("bp_hold_b", bus_if.wb_wdata_o, 2);

    // Streaming 1..8 with wb_ready_i held high
    for (int i = 1; i <= 8; i++) begin
      drive_ex(1'b1, DW'(i), AW'(i), 1'b1, 1'b0, 1'b0, '0);
      tick();
      check($sformatf("stream_data_%0d", i), bus_if.wb_wdata_o, i);
      check($sformatf("stream_valid_%0d", i), bus_if.wb_valid_o, 1);
      check($sformatf("stream_ready_%0d", i), bus_if.ex_ready_o, 1);
    end
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check("stream_drained", bus_if.wb_valid_o, 0);
    check("stream_last", bus_if.wb_wdata_o, 8);
    bus_if.wb_ready_i = 1'b0;

    // Taken branch, no register write
    drive_ex(1'b1, 32'h0000_00aa, 6'd7, 1'b0, 1'b1, 1'b1, 32'h8000_0040);
    tick();
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    check("br_taken", bus_if.branch_taken_o, 1);
    check("br_target", bus_if.branch_target_o, 32'h8000_0040);
    check("br_queued", bus_if.wb_valid_o, 1);
    check("br_we_low", bus_if.wb_we_o, 0);
    tick();
    check("br_pulse_end", bus_if.branch_taken_o, 0);
    bus_if.wb_ready_i = 1'b1;
    tick();
    check("br_retired", bus_if.wb_valid_o, 0);
    // Not-taken branch
    drive_ex(1'b1, 32'h0, 6'd0, 1'b0, 1'b1, 1'b0, 32'h0000_1000);
    tick();
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    check("br_not_taken", bus_if.branch_taken_o, 0);
    tick();
    check("br_nt_quiet", bus_if.branch_taken_o, 0);
    bus_if.wb_ready_i = 1'b0;

    // Fill to FULL, optionally inspect forwarding, then flush with a taken branch offered
    drive_ex(1'b1, 32'h0000_0011, 6'd3, 1'b1, 1'b0, 1'b0, '0);
    tick();
    drive_ex(1'b1, 32'h0000_0022, 6'd3, 1'b1, 1'b0, 1'b0, '0);
    tick();
    check("fl_full", bus_if.ex_ready_o, 0);
`ifdef RISCV_EXWB_FWD_EN
    check("fwd_valid", bus_if.fwd_valid_o, 2'b11);
    check("fwd_waddr0", bus_if.fwd_waddr_o[0], 3);
    check("fwd_waddr1", bus_if.fwd_waddr_o[1], 3);
    check("fwd_wdata0", bus_if.fwd_wdata_o[0], 32'h11);
    check("fwd_wdata1", bus_if.fwd_wdata_o[1], 32'h22);
`endif
    flush_i = 1'b1;
    drive_ex(1'b1, 32'h0000_0033, 6'd4, 1'b1, 1'b1, 1'b1, 32'h0000_2000);
    tick();
    flush_i = 1'b0;
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    check("fl_valid", bus_if.wb_valid_o, 0);
    check("fl_ready", bus_if.ex_ready_o, 1);
    check("fl_no_branch", bus_if.branch_taken_o, 0);
    bus_if.wb_ready_i = 1'b1;
    tick();
    check("fl_not_retired", bus_if.wb_valid_o, 0);
    check("fl_hold_wdata", bus_if.wb_wdata_o, 32'h11);
    bus_if.wb_ready_i = 1'b0;

    // Reset mid-operation drops the buffered entry
    drive_ex(1'b1, 32'h0000_0055, 6'd9, 1'b1, 1'b0, 1'b0, '0);
    tick();
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    check("mr_loaded", bus_if.wb_valid_o, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_valid", bus_if.wb_valid_o, 0);
    check("mr_wdata", bus_if.wb_wdata_o, 0);
    check("mr_ready", bus_if.ex_ready_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riscv_ex_wb_buffer.md
Name: riscv_ex_wb_buffer

Overview:
- Decoupling stage directly downstream of the basic ALU.
- Captures ALU result, comparison bit and destination tag each accepted cycle into a 2-entry skid buffer.
- Presents the head entry to writeback with a valid/ready handshake and resolves branch decisions from the comparison bit.
- Breaks the combinational path from writeback stall to EX stall.

Parameters:
- DATA_WIDTH, 32, width of result and branch target
- REG_ADDR_WIDTH, 6, destination register address width (includes FP bank bit)

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- flush_i  in  1  discard all buffered entries and any same-cycle input
- ex_valid_i  in  1  EX presents an entry
- ex_ready_o  out  1  buffer can accept; registered
- ex_result_i  in  DATA_WIDTH  ALU result
- ex_cmp_i  in  1  ALU comparison result
- ex_waddr_i  in  REG_ADDR_WIDTH  destination register
- ex_we_i  in  1  entry writes register file
- ex_branch_i  in  1  entry is a conditional branch
- ex_target_i  in  DATA_WIDTH  branch target
- wb_valid_o  out  1  head entry valid
- wb_ready_i  in  1  writeback consumes head
- wb_waddr_o  out  REG_ADDR_WIDTH  head destination
- wb_wdata_o  out  DATA_WIDTH  head result
- wb_we_o  out  1  head write enable, gated by wb_valid_o
- branch_taken_o  out  1  one-cycle pulse: accepted branch had ex_cmp_i=1
- branch_target_o  out  DATA_WIDTH  target qualifying branch_taken_o

Behaviour:
- Reset (rst_n=0 at posedge): state EMPTY; ex_ready_o=1; wb_valid_o=0; wb_we_o=0; branch_taken_o=0; wb_waddr_o=0; wb_wdata_o=0; branch_target_o=0.
- Reset mid-operation drops all entries; no partial writeback is emitted.
- Accept = ex_valid_i & ex_ready_o. Pop = wb_valid_o & wb_ready_i.
- States: EMPTY, ONE, FULL (2 entries, head and skid).
  - EMPTY: accept -> ONE.
  - ONE: accept & !pop -> FULL; pop & !accept -> EMPTY; accept & pop -> ONE, new entry becomes head.
  - FULL: pop -> ONE, skid moves to head. No accept is possible because ex_ready_o=0.
- ex_ready_o is registered: 1 in the cycle after state becomes EMPTY or ONE, 0 in the cycle after state becomes FULL. It never depends combinationally on wb_ready_i.
- Latency: an entry accepted at edge N appears on wb_* after N, with no bypass around the buffer. Ordering is strict FIFO.
- Branch entries:
  - branch_taken_o=ex_cmp_i and branch_target_o=ex_target_i are registered at the accept edge, giving a single-cycle pulse.
  - Branch entries with ex_we_i=0 are still queued, with wb_we_o=0, so writeback sees retirement order.
- Flush:
  - flush_i=1 at an edge -> state EMPTY, ex_ready_o=1, branch_taken_o=0, regardless of accept or pop in that cycle.
  - Flush has priority over accept.
- wb_wdata_o and wb_waddr_o hold their last value when wb_valid_o=0. No X is propagated after reset.
- Widths: all data paths are DATA_WIDTH. No arithmetic except the 2-bit occupancy.

Optional Feature:
- Macro RISCV_EXWB_FWD_EN.
- Defined: adds outputs fwd_valid_o[1:0], fwd_waddr_o[2][REG_ADDR_WIDTH], fwd_wdata_o[2][DATA_WIDTH], exposing both buffered entries to the ID operand-forwarding mux.
  - Index 0 = head, index 1 = skid.
  - fwd_valid_o[i] = entry valid & we.
  - Same-address priority is decided by the consumer: skid (younger) wins.
- Undefined: ports absent; the ID stage stalls on a register hazard until writeback completes.

Decomposition:
- riscv_defines gains:
  - exwb_state_e (EMPTY, ONE, FULL) enum, 2 bits.
  - exwb_entry_t packed struct {waddr, wdata, we}.
  - constant EXWB_DEPTH=2.
- No sub-module. The buffer is one module of a head register, a skid register and an FSM. The forwarding extraction is inline under the macro.

Test Plan:
- Reset, then single entry: ex_result_i=32'h0000_1234, waddr=5, we=1 accepted at cycle 1 -> wb_valid_o=1, wb_wdata_o=32'h1234, wb_waddr_o=5 in cycle 2; wb_ready_i=1 -> wb_valid_o=0 in cycle 3.
- Backpressure: wb_ready_i=0, push A=1 then B=2 -> ex_ready_o=0 after second accept; release wb_ready_i -> pops A then B in order; ex_ready_o=1 one cycle after the first pop.
- Streaming: ex_valid_i=1 and wb_ready_i=1 continuously with values 1..8 -> one result per cycle, state stays ONE, no lost or duplicated entries.
- Branch: ex_branch_i=1, ex_cmp_i=1, target=32'h8000_0040, we=0 -> branch_taken_o pulse exactly one cycle with that target, wb_we_o=0 for the entry; ex_cmp_i=0 -> no pulse.
- Flush in FULL with simultaneous ex_valid_i: next cycle wb_valid_o=0, ex_ready_o=1, incoming entry not retired.
- With RISCV_EXWB_FWD_EN: FULL with head waddr=3 (we=1), skid waddr=3 (we=1) -> fwd_valid_o=2'b11, fwd_wdata_o[1] = younger value.
